mips_hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the 5-stage MIPS core (F, D, E, M, W). It generates operand forwarding selects, load-use stalls and taken-branch flushes. It replaces the fixed 2-cycle memory stall counter with an FSM that waits a configurable latency plus a `mem_ready` handshake, so the core can sit in front of slower data memories.

---
 rtl/mips_pkg.sv | 17 +
 rtl/mips_mem_wait_fsm.sv | 76 +++++++
 rtl/mips_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mips_hazard_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS hazard / pipeline-control slice:
// forwarding selects, memory-wait FSM states and the hardwired-zero register.
package mips_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mem_state_t;

endpackage

// File: rtl/mips_mem_wait_fsm.sv
// M-stage memory wait FSM: holds the pipeline for at least MEM_LAT cycles in
// WAIT and then until mem_ready is seen, followed by a single DONE release cycle.
module mips_mem_wait_fsm
    import mips_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic m_mem_req,
    input  logic mem_ready,
    output logic mem_stall,
    output logic mem_busy
);

    localparam int unsigned      WCNT_W    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(MEM_LAT);
    localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

    mem_state_t        state_r;
    mem_state_t        state_nxt_s;
    logic [WCNT_W-1:0] wcnt_r;
    logic [WCNT_W-1:0] wcnt_nxt_s;

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            wcnt_r  <= WCNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
        end
    end

    // Next-state logic; mem_ready is only honoured once the minimum wait expired.
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        case (state_r)
            IDLE: begin
                if (m_mem_req) begin
                    state_nxt_s = WAIT;
                    wcnt_nxt_s  = WCNT_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if ((wcnt_r == WCNT_ZERO) && mem_ready) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
                if (wcnt_r != WCNT_ZERO) begin
                    wcnt_nxt_s = wcnt_r - WCNT_ONE;
                end else begin
                    wcnt_nxt_s = WCNT_ZERO;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                wcnt_nxt_s  = WCNT_ZERO;
            end
        endcase
    end

    // The IDLE request cycle already stalls so the access never slips through.
    assign mem_stall = ~reset & (((state_r == IDLE) & m_mem_req) | (state_r == WAIT));
    assign mem_busy  = (state_r != IDLE);

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS core: forwarding,
// load-use stall, branch flush, memory-wait stall. Macro HAZARD_PERF_CNT_EN adds perf counters.
module mips_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
`ifdef HAZARD_PERF_CNT_EN
    parameter int unsigned CNT_W      = 32,
`endif
    parameter int unsigned MEM_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] d_rs,
    input  logic [REG_ADDR_W-1:0] d_rt,
    input  logic                  d_uses_rs,
    input  logic                  d_uses_rt,
    input  logic [REG_ADDR_W-1:0] e_rs,
    input  logic [REG_ADDR_W-1:0] e_rt,
    input  logic [REG_ADDR_W-1:0] e_wr,
    input  logic                  e_regwrite,
    input  logic                  e_memtoreg,
    input  logic                  e_branch_taken,
    input  logic [REG_ADDR_W-1:0] m_wr,
    input  logic                  m_regwrite,
    input  logic                  m_memtoreg,
    input  logic                  m_mem_req,
    input  logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] w_wr,
    input  logic                  w_regwrite,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  bubble_w,
    output logic                  mem_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_lu_stalls,
    output logic [CNT_W-1:0]      perf_mem_stalls,
    output logic [CNT_W-1:0]      perf_flushes
`endif
);

    localparam logic [REG_ADDR_W-1:0] RZ = REG_ADDR_W'(REG_ZERO);

    logic mem_stall_s;
    logic lu_s;

    // M result has priority over W; loads in M are not forwardable yet.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] mwr,
        input logic                  mrw,
        input logic                  mmtr,
        input logic [REG_ADDR_W-1:0] wwr,
        input logic                  wrw
    );
        logic [1:0] sel;
        if ((src != RZ) && (src == mwr) && mrw && !mmtr) begin
            sel = FWD_M;
        end else if ((src != RZ) && (src == wwr) && wrw) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    mips_mem_wait_fsm #(
        .MEM_LAT (MEM_LAT)
    ) u_mem_fsm (
        .clk       (clk),
        .reset     (reset),
        .m_mem_req (m_mem_req),
        .mem_ready (mem_ready),
        .mem_stall (mem_stall_s),
        .mem_busy  (mem_busy)
    );

    assign lu_s = e_memtoreg & e_regwrite & (e_wr != RZ) &
                  ((d_uses_rs & (d_rs == e_wr)) | (d_uses_rt & (d_rt == e_wr)));

    // Output priority: reset, then memory freeze, then branch over load-use.
    always_comb begin
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        bubble_w = 1'b0;
        if (reset) begin
            fwd_a = FWD_RF;
        end else begin
            fwd_a = fwd_sel(e_rs, m_wr, m_regwrite, m_memtoreg, w_wr, w_regwrite);
            fwd_b = fwd_sel(e_rt, m_wr, m_regwrite, m_memtoreg, w_wr, w_regwrite);
            if (mem_stall_s) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                stall_e  = 1'b1;
                stall_m  = 1'b1;
                bubble_w = 1'b1;
            end else begin
                flush_d = e_branch_taken;
                flush_e = e_branch_taken | lu_s;
                stall_f = lu_s & ~e_branch_taken;
                stall_d = lu_s & ~e_branch_taken;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic lu_evt_s;
    logic br_evt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    assign lu_evt_s = ~reset & ~mem_stall_s & lu_s & ~e_branch_taken;
    assign br_evt_s = ~reset & ~mem_stall_s & e_branch_taken;

    // Saturating event counters for driven stalls and flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lu_stalls  <= {CNT_W{1'b0}};
            perf_mem_stalls <= {CNT_W{1'b0}};
            perf_flushes    <= {CNT_W{1'b0}};
        end else begin
            if (lu_evt_s) begin
                perf_lu_stalls <= sat_inc(perf_lu_stalls);
            end else begin
                perf_lu_stalls <= perf_lu_stalls;
            end
            if (mem_stall_s) begin
                perf_mem_stalls <= sat_inc(perf_mem_stalls);
            end else begin
                perf_mem_stalls <= perf_mem_stalls;
            end
            if (br_evt_s) begin
                perf_flushes <= sat_inc(perf_flushes);
            end else begin
                perf_flushes <= perf_flushes;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Self-checking bench for mips_hazard_ctrl: one instance with MEM_LAT=2 and one
// with MEM_LAT=1, expectations queued at drive time and popped at sample time.
module tb_mips_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_rs, e_rt, e_wr, m_wr, w_wr;
    logic       d_uses_rs, d_uses_rt, e_regwrite, e_memtoreg, e_branch_taken;
    logic       m_regwrite, m_memtoreg, m_mem_req, mem_ready, w_regwrite;
    logic       m_mem_req1, mem_ready1;

    logic [1:0] fwd_a, fwd_b, fwd_a1, fwd_b1;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w, mem_busy;
    logic       stall_f1, stall_d1, stall_e1, stall_m1, flush_d1, flush_e1, bubble_w1, mem_busy1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_stalls, perf_mem_stalls, perf_flushes;
    logic [31:0] perf_lu_stalls1, perf_mem_stalls1, perf_flushes1;
`endif

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] st;
        logic [1:0] fl;
        logic       bw;
        logic       busy;
    } exp_t;

    typedef struct packed {
        logic [4:0] ers, ert, mwr;
        logic       mrw, mmtr;
        logic [4:0] wwr;
        logic       wrw;
        logic [1:0] fa, fb;
    } fwd_row_t;

    typedef struct packed {
        logic       mtr, rw;
        logic [4:0] ewr, drs;
        logic       urs;
        logic [4:0] drt;
        logic       urt, br;
        logic [3:0] st;
        logic [1:0] fl;
    } lu_row_t;

    typedef struct packed {
        logic       rst, req, rdy, br;
        logic [3:0] st;
        logic [1:0] fl;
        logic       bw, busy;
    } mem_row_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total;
    int    bad;

    mips_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .e_rs(e_rs), .e_rt(e_rt),
        .e_wr(e_wr), .e_regwrite(e_regwrite), .e_memtoreg(e_memtoreg),
        .e_branch_taken(e_branch_taken), .m_wr(m_wr), .m_regwrite(m_regwrite),
        .m_memtoreg(m_memtoreg), .m_mem_req(m_mem_req), .mem_ready(mem_ready),
        .w_wr(w_wr), .w_regwrite(w_regwrite), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .bubble_w(bubble_w), .mem_busy(mem_busy)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu_stalls(perf_lu_stalls), .perf_mem_stalls(perf_mem_stalls),
        .perf_flushes(perf_flushes)
`endif
    );

    mips_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .e_rs(e_rs), .e_rt(e_rt),
        .e_wr(e_wr), .e_regwrite(e_regwrite), .e_memtoreg(e_memtoreg),
        .e_branch_taken(e_branch_taken), .m_wr(m_wr), .m_regwrite(m_regwrite),
        .m_memtoreg(m_memtoreg), .m_mem_req(m_mem_req1), .mem_ready(mem_ready1),
        .w_wr(w_wr), .w_regwrite(w_regwrite), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
        .stall_f(stall_f1), .stall_d(stall_d1), .stall_e(stall_e1), .stall_m(stall_m1),
        .flush_d(flush_d1), .flush_e(flush_e1), .bubble_w(bubble_w1), .mem_busy(mem_busy1)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu_stalls(perf_lu_stalls1), .perf_mem_stalls(perf_mem_stalls1),
        .perf_flushes(perf_flushes1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                                input logic [3:0] st, input logic [1:0] fl,
                                input logic bw, input logic busy);
        exp_t e;
        e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.bw = bw; e.busy = busy;
        return e;
    endfunction

    function automatic exp_t obs0();
        return mk(fwd_a, fwd_b, {stall_f, stall_d, stall_e, stall_m},
                  {flush_d, flush_e}, bubble_w, mem_busy);
    endfunction

    function automatic exp_t obs1();
        return mk(fwd_a1, fwd_b1, {stall_f1, stall_d1, stall_e1, stall_m1},
                  {flush_d1, flush_e1}, bubble_w1, mem_busy1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        d_rs = 5'd0; d_rt = 5'd0; d_uses_rs = 1'b0; d_uses_rt = 1'b0;
        e_rs = 5'd0; e_rt = 5'd0; e_wr = 5'd0;
        e_regwrite = 1'b0; e_memtoreg = 1'b0; e_branch_taken = 1'b0;
        m_wr = 5'd0; m_regwrite = 1'b0; m_memtoreg = 1'b0;
        m_mem_req = 1'b0; mem_ready = 1'b1;
        m_mem_req1 = 1'b0; mem_ready1 = 1'b1;
        w_wr = 5'd0; w_regwrite = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got, want;
        string tag;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) begin
                reset = 1'b1;
                e_rs = 5'd3; m_wr = 5'd3; m_regwrite = 1'b1; w_wr = 5'd3; w_regwrite = 1'b1;
                e_memtoreg = 1'b1; e_regwrite = 1'b1; e_wr = 5'd5; d_rt = 5'd5;
                d_uses_rt = 1'b1; e_branch_taken = 1'b1; m_mem_req = 1'b1;
            end else begin
                clear_inputs();
                reset = 1'b0;
            end
            exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0));
            tag_q.push_back("reset");
            #2;
            got = obs0(); want = exp_q.pop_front(); tag = tag_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s[%0d]: got=%b want=%b", tag, i, got, want);
            end
        end
    endtask

    task automatic test_forwarding();
        fwd_row_t rows[6];
        exp_t got, want;
        string tag;
        rows = '{
            '{5'd3,  5'd7,  5'd3, 1'b1, 1'b0, 5'd3,  1'b1, 2'b10, 2'b00},
            '{5'd3,  5'd7,  5'd3, 1'b0, 1'b0, 5'd3,  1'b1, 2'b01, 2'b00},
            '{5'd0,  5'd7,  5'd0, 1'b1, 1'b0, 5'd0,  1'b1, 2'b00, 2'b00},
            '{5'd5,  5'd4,  5'd5, 1'b1, 1'b1, 5'd4,  1'b1, 2'b00, 2'b01},
            '{5'd9,  5'd9,  5'd9, 1'b1, 1'b0, 5'd9,  1'b0, 2'b10, 2'b10},
            '{5'd12, 5'd12, 5'd1, 1'b1, 1'b0, 5'd12, 1'b1, 2'b01, 2'b01}
        };
        for (int i = 0; i < 6; i++) begin
            tick();
            e_rs = rows[i].ers; e_rt = rows[i].ert; m_wr = rows[i].mwr;
            m_regwrite = rows[i].mrw; m_memtoreg = rows[i].mmtr;
            w_wr = rows[i].wwr; w_regwrite = rows[i].wrw;
            exp_q.push_back(mk(rows[i].fa, rows[i].fb, 4'b0000, 2'b00, 1'b0, 1'b0));
            tag_q.push_back("fwd");
            #2;
            got = obs0(); want = exp_q.pop_front(); tag = tag_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s[%0d]: got=%b want=%b", tag, i, got, want);
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_load_use();
        lu_row_t rows[8];
        exp_t got, want;
        string tag;
        rows = '{
            '{1'b1, 1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 4'b1100, 2'b01},
            '{1'b0, 1'b0, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 4'b0000, 2'b00},
            '{1'b1, 1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, 4'b0000, 2'b00},
            '{1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd9, 1'b0, 1'b0, 4'b1100, 2'b01},
            '{1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 4'b0000, 2'b00},
            '{1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 4'b0000, 2'b00},
            '{1'b1, 1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 4'b0000, 2'b11},
            '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b0000, 2'b11}
        };
        for (int i = 0; i < 8; i++) begin
            tick();
            e_memtoreg = rows[i].mtr; e_regwrite = rows[i].rw; e_wr = rows[i].ewr;
            d_rs = rows[i].drs; d_uses_rs = rows[i].urs;
            d_rt = rows[i].drt; d_uses_rt = rows[i].urt;
            e_branch_taken = rows[i].br;
            exp_q.push_back(mk(2'b00, 2'b00, rows[i].st, rows[i].fl, 1'b0, 1'b0));
            tag_q.push_back(i < 6 ? "load_use" : "branch");
            #2;
            got = obs0(); want = exp_q.pop_front(); tag = tag_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s[%0d]: got=%b want=%b", tag, i, got, want);
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_latency();
        mem_row_t rows[7];
        exp_t got, want;
        string tag;
        rows = '{
            '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 2'b00, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 2'b00, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 2'b00, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 2'b00, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0}
        };
        for (int i = 0; i < 7; i++) begin
            tick();
            m_mem_req = rows[i].req; mem_ready = rows[i].rdy; e_branch_taken = rows[i].br;
            exp_q.push_back(mk(2'b00, 2'b00, rows[i].st, rows[i].fl, rows[i].bw, rows[i].busy));
            tag_q.push_back("mem_lat2");
            #2;
            got = obs0(); want = exp_q.pop_front(); tag = tag_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s[%0d]: got=%b want=%b", tag, i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, want;
        string tag;
        logic [3:0] st;
        logic       bw, busy, req;
        for (int i = 0; i < 11; i++) begin
            tick();
            req = (i < 10) ? 1'b1 : 1'b0;
            m_mem_req = req; mem_ready = 1'b1;
            case (i)
                0, 5:    begin st = 4'b1111; bw = 1'b1; busy = 1'b0; end
                4, 9:    begin st = 4'b0000; bw = 1'b0; busy = 1'b1; end
                10:      begin st = 4'b0000; bw = 1'b0; busy = 1'b0; end
                default: begin st = 4'b1111; bw = 1'b1; busy = 1'b1; end
            endcase
            exp_q.push_back(mk(2'b00, 2'b00, st, 2'b00, bw, busy));
            tag_q.push_back("back_to_back");
            #2;
            got = obs0(); want = exp_q.pop_front(); tag = tag_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s[%0d]: got=%b want=%b", tag, i, got, want);
            end
        end
    endtask

    task automatic test_slow_mem();
        exp_t got, want;
        string tag;
        logic [3:0] st;
        logic       bw, busy;
        for (int i = 0; i < 10; i++) begin
            tick();
            m_mem_req1 = (i < 9) ? 1'b1 : 1'b0;
            mem_ready1 = (i == 1 || i == 7) ? 1'b1 : 1'b0;
            if (i == 0) begin
                st = 4'b1111; bw = 1'b1; busy = 1'b0;
            end else if (i < 8) begin
                st = 4'b1111; bw = 1'b1; busy = 1'b1;
            end else if (i == 8) begin
                st = 4'b0000; bw = 1'b0; busy = 1'b1;
            end else begin
                st = 4'b0000; bw = 1'b0; busy = 1'b0;
            end
            exp_q.push_back(mk(2'b00, 2'b00, st, 2'b00, bw, busy));
            tag_q.push_back("slow_mem_lat1");
            #2;
            got = obs1(); want = exp_q.pop_front(); tag = tag_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s[%0d]: got=%b want=%b", tag, i, got, want);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        mem_row_t rows[6];
        exp_t got, want;
        string tag;
        rows = '{
            '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 2'b00, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 2'b00, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 2'b00, 1'b1, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0}
        };
        tick();
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
`ifdef HAZARD_PERF_CNT_EN
            if (i == 3) begin
                total++;
                if (perf_mem_stalls !== 32'd3) begin
                    bad++;
                    $display("FAIL perf_mem_before_reset: got=%0d want=3", perf_mem_stalls);
                end
            end
`endif
            reset = rows[i].rst; m_mem_req = rows[i].req; mem_ready = rows[i].rdy;
            exp_q.push_back(mk(2'b00, 2'b00, rows[i].st, rows[i].fl, rows[i].bw, rows[i].busy));
            tag_q.push_back("reset_mid_wait");
            #2;
            got = obs0(); want = exp_q.pop_front(); tag = tag_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s[%0d]: got=%b want=%b", tag, i, got, want);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (i == 3) begin
                total++;
                if (perf_mem_stalls !== 32'd0) begin
                    bad++;
                    $display("FAIL perf_mem_after_reset: got=%0d want=0", perf_mem_stalls);
                end
            end
`endif
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_latency();
        test_back_to_back();
        test_slow_mem();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
